// File: rtl/fifo_rd_pkg.sv
// Shared constants and pointer helper for the FIFO read-side prefetch stage.
package fifo_rd_pkg;

  localparam int unsigned PF_DEPTH = 3;
  localparam int unsigned PF_PTR_W = 2;
  localparam int unsigned RD_LAT   = 1;

  typedef logic [PF_PTR_W-1:0] pf_ptr_t;

  // Pointers walk 0,1,2,0,... rather than the full 2-bit range.
  function automatic pf_ptr_t ptr_inc(input pf_ptr_t p);
    return (p == pf_ptr_t'(PF_DEPTH - 1)) ? pf_ptr_t'(0) : p + pf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_prefetch_if.sv
// FIFO read port plus downstream valid/ready stream of the prefetch stage.
interface fifo_rd_prefetch_if #(
  parameter int DSIZE = 32
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    input  rempty, rdata, dout_ready,
    output rinc, dout, dout_valid
  );

  modport slave (
    output rempty, rdata, dout_ready,
    input  rinc, dout, dout_valid
  );
endinterface

// File: rtl/fifo_rd_pf_buf.sv
// Three-entry circular register file with write/pop pointers and occupancy.
module fifo_rd_pf_buf
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_ready,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  output pf_ptr_t          occ
);
  logic [DSIZE-1:0] ent_q [PF_DEPTH];
  logic [DSIZE-1:0] ent_d [PF_DEPTH];
  pf_ptr_t head_q, head_d;
  pf_ptr_t tail_q, tail_d;
  pf_ptr_t occ_q, occ_d;
  logic    pop;

  assign rd_valid = (occ_q != '0);
  assign occ      = occ_q;
  // A ready with nothing valid is simply ignored.
  assign pop      = rd_valid & rd_ready;

  genvar gi;
  for (gi = 0; gi < int'(PF_DEPTH); gi++) begin : g_ent
    always_comb begin
      ent_d[gi] = ent_q[gi];
      if (wr_en && tail_q == pf_ptr_t'(gi)) ent_d[gi] = wr_data;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) ent_q[gi] <= '0;
      else        ent_q[gi] <= ent_d[gi];
    end
  end

  always_comb begin
    head_d = pop   ? ptr_inc(head_q) : head_q;
    tail_d = wr_en ? ptr_inc(tail_q) : tail_q;
    occ_d  = occ_q + pf_ptr_t'(wr_en) - pf_ptr_t'(pop);
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(PF_DEPTH); i++) begin
      if (head_q == pf_ptr_t'(i)) rd_data = ent_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage behind the async FIFO; FIFO_RD_STATS_EN adds
// saturating delivered-word and stall-cycle counters.
module fifo_rd_prefetch
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int CNT_W = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  fifo_rd_prefetch_if.master bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);
  if (DSIZE < 1 || CNT_W < 1) begin : g_bad_params
    $error("fifo_rd_prefetch: DSIZE and CNT_W must be positive");
  end

  logic            inflight_q, inflight_d;
  pf_ptr_t         occ;
  logic [PF_PTR_W:0] committed;
  logic            rinc;

  // Issue only from registered state so dout_ready never reaches rinc.
  assign committed = {1'b0, occ} + {{PF_PTR_W{1'b0}}, inflight_q};
  assign rinc      = rrst_n & ~bus.rempty & (committed < (PF_PTR_W+1)'(PF_DEPTH));
  assign bus.rinc  = rinc;

  always_comb inflight_d = rinc;

  always_ff @(posedge rclk) begin
    if (!rrst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  fifo_rd_pf_buf #(.DSIZE(DSIZE)) u_buf (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .wr_en    (inflight_q),
    .wr_data  (bus.rdata),
    .rd_ready (bus.dout_ready),
    .rd_data  (bus.dout),
    .rd_valid (bus.dout_valid),
    .occ      (occ)
  );

`ifdef FIFO_RD_STATS_EN
  logic             pop, stall;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pop   = bus.dout_valid & bus.dout_ready;
  assign stall = bus.dout_valid & ~bus.dout_ready;

  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && word_cnt_q != '1)    word_cnt_d  = word_cnt_q + 1'b1;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Scoreboard bench: FIFO/SRAM modelled with queues, monitor checks delivered order and hold rules.
module tb_fifo_rd_prefetch;
  localparam int DW = 32;
`ifdef FIFO_RD_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rrst_n;
  always #5 clk = ~clk;

  fifo_rd_prefetch_if #(.DSIZE(DW)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] word_cnt, stall_cnt;
`endif

  fifo_rd_prefetch #(.DSIZE(DW), .CNT_W(CW)) dut (
    .rclk   (clk),
    .rrst_n (rrst_n),
    .bus    (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit hold_empty = 1'b0;
  logic s_rinc, s_valid;
  logic [DW-1:0] s_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic upd_rempty();
    bus.rempty = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    upd_rempty();
  endtask

  // One clock: sample outputs mid-cycle, then model the FIFO/SRAM reaction to the edge.
  task automatic step();
    @(negedge clk);
    s_rinc  = bus.rinc;
    s_valid = bus.dout_valid;
    s_dout  = bus.dout;
    @(posedge clk);
    #1;
    if (!rrst_n) begin
      fifo_q.delete();
      exp_q.delete();
      bus.rdata = $urandom;
    end else if (s_rinc) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow actual=read required=no_read");
        bus.rdata = $urandom;
      end else begin
        bus.rdata = fifo_q.pop_front();
      end
    end else begin
      bus.rdata = $urandom;
    end
    upd_rempty();
  endtask

  // Monitor: every accepted word must be the next expected one; held words must not move.
  initial begin
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_dout = '0;
    forever begin
      @(negedge clk);
      if (rrst_n === 1'b1) begin
        if (bus.rinc && bus.rempty) check("rinc_while_empty", 32'(bus.rinc), 32'd0);
        if (prev_stall) begin
          check("hold_valid", 32'(bus.dout_valid), 32'd1);
          check("hold_data", bus.dout, prev_dout);
        end
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=no_word", bus.dout);
          end else begin
            check("pop_data", bus.dout, exp_q.pop_front());
          end
        end
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int nr, nv, first, last;
    rrst_n = 1'b0;
    bus.dout_ready = 1'b1;
    bus.rdata = '0;
    bus.rempty = 1'b0;

    // Reset held with a non-empty FIFO
    for (int k = 0; k < 3; k++) begin
      step();
      bus.rempty = 1'b0;
      check("rst_rinc", 32'(s_rinc), 32'd0);
      check("rst_valid", 32'(s_valid), 32'd0);
      check("rst_dout", s_dout, 32'd0);
    end
    rrst_n = 1'b1;
    preload(4, 32'hA0);
    step();
    check("rst_first_rinc", 32'(s_rinc), 32'd1);
    for (int k = 0; k < 10; k++) step();
    check("rst_drain", 32'(exp_q.size()), 32'd0);

    // Single word: rinc in cycle 0, dout_valid in cycle 2 only
    preload(1, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("single_rinc_c%0d", k), 32'(s_rinc), 32'(k == 0));
      check($sformatf("single_valid_c%0d", k), 32'(s_valid), 32'(k == 2));
      if (k == 2) check("single_dout", s_dout, 32'hDEADBEEF);
    end

    // Streaming 32 words at full rate
    preload(32, 32'h0);
    nr = 0; nv = 0; first = -1; last = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_rinc) nr++;
      if (s_valid) begin
        if (first < 0) first = k;
        nv++;
        last = k;
      end
    end
    check("stream_rinc_count", 32'(nr), 32'd32);
    check("stream_first_valid", 32'(first), 32'd2);
    check("stream_valid_count", 32'(nv), 32'd32);
    check("stream_contiguous", 32'(last - first), 32'd31);

    // Backpressure: three reads fill the buffer, head word held
    bus.dout_ready = 1'b0;
    preload(10, 32'h200);
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_rinc) nr++;
    end
    check("bp_rinc_count", 32'(nr), 32'd3);
    check("bp_occ", 32'(dut.u_buf.occ_q), 32'd3);
    check("bp_valid", 32'(s_valid), 32'd1);
    check("bp_dout", s_dout, 32'h200);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset with a word in flight
    preload(20, 32'h300);
    for (int k = 0; k < 5; k++) step();
    check("mid_inflight", 32'(s_rinc), 32'd1);
    rrst_n = 1'b0;
    step();
    check("mid_rst_rinc", 32'(s_rinc), 32'd0);
    rrst_n = 1'b1;
    step();
    check("mid_valid", 32'(s_valid), 32'd0);
    check("mid_occ", 32'(dut.u_buf.occ_q), 32'd0);
    preload(4, 32'h400);
    for (int k = 0; k < 12; k++) step();
    check("mid_drain", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_STATS_EN
    // 20 pops saturate a 4-bit counter; 5 stall cycles
    rrst_n = 1'b0;
    step();
    rrst_n = 1'b1;
    preload(20, 32'h500);
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 7; k++) step();
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 30; k++) step();
    check("stats_word_cnt", 32'(word_cnt), 32'd15);
    check("stats_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Randomised traffic with random empty gaps and backpressure
    for (int c = 0; c < 3000; c++) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 7) == 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0)
        preload(int'($urandom_range(1, 6)), DW'($urandom));
      else
        upd_rempty();
      step();
    end
    hold_empty = 1'b0;
    bus.dout_ready = 1'b1;
    upd_rempty();
    for (int k = 0; k < 40; k++) step();
    check("rand_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
